serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Smallest counter width able to index WIDTH bits; never less than 1.
  function automatic int unsigned cnt_width(input int unsigned w);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < w) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell driven by the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic sum,
  output logic carry_out
);

  assign sum       = a ^ b ^ carry_in;
  assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial two's-complement adder: operands are shifted LSB-first through
// one full_adder with a registered carry; result returned over valid/ready.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned     CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sum_next;

  full_adder u_fa (
    .a         (r_a_sh[0]),
    .b         (r_b_sh[0]),
    .carry_in  (r_carry),
    .sum       (w_fa_sum),
    .carry_out (w_fa_cout)
  );

  assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum_sh    <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a_sh     <= a;
            r_b_sh     <= b;
            r_carry    <= cin;
            r_count    <= '0;
            r_sum_sh   <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end

        SHIFT: begin
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_sum_sh <= w_sum_next;
          r_carry  <= w_fa_cout;
          r_count  <= r_count + CW'(1);
          // Last step: pre-step carry is the carry into the MSB, so the
          // registered result can be formed here without an extra cycle.
          if (r_count == LAST) begin
            r_sum       <= w_sum_next;
            r_cout      <= w_fa_cout;
            r_ovf       <= r_carry ^ w_fa_cout;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end

        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16 against a
// transaction-level arithmetic model plus directed literal expectations.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v       [2];
  logic        in_valid_v  [2];
  logic        out_ready_v [2];
  logic [31:0] a_v         [2];
  logic [31:0] b_v         [2];
  logic        cin_v       [2];
  logic        in_ready_w  [2];
  logic        out_valid_w [2];
  logic        cout_w      [2];
  logic        ovf_w       [2];
  logic [7:0]  sum8;
  logic [15:0] sum16;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]),
    .sum(sum8), .cout(cout_w[0]), .ovf(ovf_w[0])
  );

  serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .cin(cin_v[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]),
    .sum(sum16), .cout(cout_w[1]), .ovf(ovf_w[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int unsigned wof(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic logic [33:0] dut_res(input int k);
    logic [31:0] s;
    s = (k == 0) ? {24'd0, sum8} : {16'd0, sum16};
    return {ovf_w[k], cout_w[k], s};
  endfunction

  // Reference: {ovf, cout, sum} of a+b+cin at width w.
  function automatic logic [33:0] ref_add(input int unsigned w, input logic [31:0] av,
                                          input logic [31:0] bv, input logic cv);
    logic [32:0] full;
    logic [31:0] m, s, am, bm;
    logic        co, ov;
    m    = (w == 32) ? '1 : ((32'd1 << w) - 32'd1);
    am   = av & m;
    bm   = bv & m;
    full = {1'b0, am} + {1'b0, bm} + {32'd0, cv};
    s    = full[31:0] & m;
    co   = full[w];
    ov   = (am[w-1] == bm[w-1]) && (s[w-1] != am[w-1]);
    return {ov, co, s};
  endfunction

  function automatic void chk(input int k, input string nm, input logic [33:0] act,
                              input logic [33:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL W%0d %s: got %h, required %h (t=%0t)", wof(k), nm, act, exp, $time);
    end
  endfunction

  function automatic void chk1(input int k, input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL W%0d %s: got %b, required %b (t=%0t)", wof(k), nm, act, exp, $time);
    end
  endfunction

  // Transaction model: busy from acceptance until the result handshake;
  // result visible WIDTH edges after acceptance.
  bit          m_known [2] = '{1'b0, 1'b0};
  bit          m_busy  [2];
  int unsigned m_t     [2];
  bit          m_chk   [2];
  logic [33:0] m_res   [2];
  logic [33:0] m_pend  [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_v[k]) begin
        m_known[k] <= 1'b1;
        m_busy[k]  <= 1'b0;
        m_t[k]     <= 0;
        m_chk[k]   <= 1'b1;
        m_res[k]   <= '0;
      end else if (m_known[k]) begin
        if (!m_busy[k]) begin
          if (in_valid_v[k]) begin
            m_busy[k] <= 1'b1;
            m_t[k]    <= 0;
            m_chk[k]  <= 1'b0;
            m_pend[k] <= ref_add(wof(k), a_v[k], b_v[k], cin_v[k]);
          end
        end else if (m_t[k] < wof(k)) begin
          m_t[k] <= m_t[k] + 1;
          if (m_t[k] + 1 == wof(k)) begin
            m_chk[k] <= 1'b1;
            m_res[k] <= m_pend[k];
          end
        end else if (out_ready_v[k]) begin
          m_busy[k] <= 1'b0;
          m_chk[k]  <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_known[k]) begin
        chk1(k, "model in_ready", in_ready_w[k], !m_busy[k]);
        chk1(k, "model out_valid", out_valid_w[k], m_busy[k] && (m_t[k] == wof(k)));
        if (m_chk[k]) chk(k, "model result", dut_res(k), m_res[k]);
      end
    end
  end

  task automatic issue(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv);
    bit acc = 1'b0;
    int n   = 0;
    a_v[k] = av; b_v[k] = bv; cin_v[k] = cv; in_valid_v[k] = 1'b1;
    while (!acc && n < 200) begin
      acc = (in_ready_w[k] === 1'b1);
      @(negedge clk);
      n++;
    end
    in_valid_v[k] = 1'b0;
    chk1(k, "accept timeout", acc, 1'b1);
  endtask

  // Returns at the first negedge with out_valid high; n = edges waited.
  task automatic wait_valid(input int k, output int n);
    n = 0;
    while (out_valid_w[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1(k, "valid timeout", out_valid_w[k], 1'b1);
  endtask

  task automatic drain(input int k, input bit rnd);
    bit done = 1'b0;
    int n    = 0;
    while (!done && n < 400) begin
      out_ready_v[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid_w[k] === 1'b1 && out_ready_v[k]) done = 1'b1;
      else if (rnd) begin
        in_valid_v[k] = 1'($urandom_range(0, 1));
        a_v[k] = $urandom;
        b_v[k] = $urandom;
      end
      @(negedge clk);
      n++;
    end
    in_valid_v[k]  = 1'b0;
    out_ready_v[k] = 1'b0;
    chk1(k, "drain timeout", done, 1'b1);
  endtask

  task automatic run_dir(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic [33:0] exp);
    int n;
    issue(0, {24'd0, av}, {24'd0, bv}, cv);
    wait_valid(0, n);
    chk(0, "latency", 34'(n), 34'd8);
    chk(0, "directed result", dut_res(0), exp);
    drain(0, 1'b0);
  endtask

  task automatic rand_loop(input int k);
    for (int i = 0; i < 1000; i++) begin
      issue(k, $urandom, $urandom, 1'($urandom_range(0, 1)));
      drain(k, 1'b1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst_v[k] = 1'b1; in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
      a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b0; rst_v[1] = 1'b0;

    chk(0, "ref 5A+A5", ref_add(8, 32'h5A, 32'hA5, 1'b0), {2'b00, 32'hFF});
    chk(0, "ref 7F+01", ref_add(8, 32'h7F, 32'h01, 1'b0), {2'b10, 32'h80});
    chk(1, "ref FFFF+1", ref_add(16, 32'hFFFF, 32'h1, 1'b0), {2'b01, 32'h0});

    chk1(0, "reset in_ready", in_ready_w[0], 1'b1);
    chk1(0, "reset out_valid", out_valid_w[0], 1'b0);
    chk(0, "reset result", dut_res(0), 34'd0);

    run_dir(8'h5A, 8'hA5, 1'b0, {2'b00, 32'hFF});
    run_dir(8'hFF, 8'h01, 1'b0, {2'b01, 32'h00});
    run_dir(8'h7F, 8'h01, 1'b0, {2'b10, 32'h80});
    run_dir(8'h00, 8'h00, 1'b1, {2'b00, 32'h01});
    run_dir(8'h80, 8'h80, 1'b0, {2'b11, 32'h00});

    // Stall in DONE with a competing request that must be ignored.
    issue(0, 32'h12, 32'h34, 1'b0);
    wait_valid(0, n);
    repeat (5) begin
      in_valid_v[0] = 1'b1; a_v[0] = 32'h11; b_v[0] = 32'h0;
      @(negedge clk);
      chk1(0, "hold out_valid", out_valid_w[0], 1'b1);
      chk1(0, "hold in_ready", in_ready_w[0], 1'b0);
      chk(0, "hold result", dut_res(0), {2'b00, 32'h46});
    end
    in_valid_v[0] = 1'b0;
    drain(0, 1'b0);
    chk1(0, "idle after release", in_ready_w[0], 1'b1);
    run_dir(8'h22, 8'h33, 1'b0, {2'b00, 32'h55});

    // Request raised in the DONE->IDLE cycle is taken one edge later.
    issue(0, 32'h01, 32'h01, 1'b1);
    wait_valid(0, n);
    out_ready_v[0] = 1'b1;
    a_v[0] = 32'h40; b_v[0] = 32'h40; cin_v[0] = 1'b0; in_valid_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    chk1(0, "b2b not taken", in_ready_w[0], 1'b1);
    chk1(0, "b2b out_valid low", out_valid_w[0], 1'b0);
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    chk1(0, "b2b taken", in_ready_w[0], 1'b0);
    wait_valid(0, n);
    chk(0, "b2b latency", 34'(n), 34'd8);
    chk(0, "b2b result", dut_res(0), {2'b10, 32'h80});
    drain(0, 1'b0);

    // Abort mid-shift.
    issue(0, 32'hF0, 32'h0F, 1'b0);
    repeat (3) @(negedge clk);
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    chk1(0, "abort in_ready", in_ready_w[0], 1'b1);
    chk1(0, "abort out_valid", out_valid_w[0], 1'b0);
    chk(0, "abort result", dut_res(0), 34'd0);
    repeat (12) begin
      @(negedge clk);
      chk1(0, "abort no result", out_valid_w[0], 1'b0);
    end
    run_dir(8'h01, 8'h02, 1'b0, {2'b00, 32'h03});

    fork
      rand_loop(0);
      rand_loop(1);
    join

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
